motor_arranque_scheduler: RTL and testbench
===========================================

# motor_arranque_scheduler

Soft-start scheduler for a bank of motors that share one inrush budget. It accepts start requests from `N_MOTORES` motors and grants the ramp to one motor at a time, in round-robin order. It steps the granted motor through the 30 % → 50 % → 100 % levels with programmable dwell times. It sits above the per-motor ramp stages and drives their level codes.

## Interface
- `N_MOTORES`, 4: number of motors (2–8).
- `CNT_W`, 16: dwell counter width.
- `DWELL_30`, 1000: cycles held at 30 % (1 … 2^CNT_W−1).
- `DWELL_50`, 1000: cycles held at 50 % (1 … 2^CNT_W−1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_MOTORES  level request per motor; 1 = run, 0 = stop.
- `rapido`  in  N_MOTORES  per-motor fast start; sampled at grant.
- `nivel`  out  2·N_MOTORES  per-motor level code, motor i at [2i+1:2i]: 00 off, 01 30 %, 10 50 %, 11 100 %.
- `busy`  out  1  a ramp is in progress.
- `grant_idx`  out  $clog2(N_MOTORES)  motor currently ramping; valid when `busy`.
- `done`  out  1  one-cycle pulse when a motor reaches 100 %.

## Operation
- States: IDLE, R30, R50.
- `running[i]` is set when motor i reaches 100 % and cleared when `req[i]` = 0.
- Pending motors: `req & ~running`, excluding the motor currently ramping.
- IDLE with any pending motor: round-robin selection starting at `rr_ptr`.
  - Latch `grant_idx`, load the dwell counter, advance `rr_ptr` to `grant_idx`+1 (mod N).
  - Next state: R30, or R50 if `rapido[grant_idx]` = 1.
- R30: granted motor at level 01. Counter expires → R50 and load DWELL_50.
- R50: granted motor at level 10. Counter expires → set `running`, level 11, pulse `done`, return to IDLE.
- Abort: `req[grant_idx]` = 0 during R30 or R50.
  - Level goes to 00 on the next edge; state returns to IDLE; no `done`.
  - Abort wins over dwell expiry in the same cycle.
- A running motor whose `req` drops goes to level 00 on the next edge, independent of scheduler state.
- Motors that are neither granted nor running stay at 00.
- Changes to `rapido` after grant are ignored until the next grant.
- Counter: down-counter of CNT_W bits, loaded with DWELL−1; expiry at 0. No wrap; it is reloaded on every state entry.
- Reset (asynchronous, any time, including mid-ramp):
  - all `nivel` = 00, `running` = 0, state IDLE, `rr_ptr` = 0;
  - `busy` = 0, `grant_idx` = 0, `done` = 0.

## Timing
- All outputs are registered.
- Request to first level: a `req` rising at edge k is seen in IDLE. Grant and level 01 (or 10) appear after edge k+1.
- Level 01 lasts exactly DWELL_30 cycles. Level 10 lasts exactly DWELL_50 cycles.
- Level 11 and `done` appear on the same edge; `done` is high for one cycle.
- Back-to-back ramps: after `done`, the scheduler spends one cycle in IDLE, and the next grant appears on the following edge.
  - Grant spacing: DWELL_30 + DWELL_50 + 1 cycles (DWELL_50 + 1 for a fast start).
- Abort latency: 1 cycle from `req` low to level 00 and `busy` low.
- `busy` is high exactly in R30 and R50.

## Structure
- Package `arranque_pkg`:
  - enum `estado_sched_t` {IDLE, R30, R50};
  - constants NIVEL_OFF = 2'b00, NIVEL_30 = 2'b01, NIVEL_50 = 2'b10, NIVEL_100 = 2'b11.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs `pending`, `ptr`;
  - outputs `valid`, `idx`;
  - purely combinational; the scheduler instantiates it once.
- Everything else lives in one module: FSM, dwell counter, `running` vector, `rr_ptr`, level register file.

## Test plan
- N=4, DWELL_30=3, DWELL_50=2. `req`=0001 held → motor 0: 01 for 3 cycles, 10 for 2 cycles, then 11 with a one-cycle `done`; `busy` falls on the same edge.
- `req`=1111 asserted together, `rr_ptr`=0 → grants in order 0, 1, 2, 3, spaced 6 cycles apart; all four end at 11.
- `rapido`=0010, `req`=0010 → motor 1 goes 00 → 10 for 2 cycles → 11; it never shows 01.
- Motor 2 in R30: drop `req[2]` on the same cycle its counter hits 0 → next edge level 00, IDLE, no `done`; a pending motor 3 is granted one cycle later.
- Motors 0 and 1 at 100 %: drop `req[0]` while motor 2 ramps → `nivel[1:0]` = 00 after one edge; the ramp of motor 2 is unaffected.
- Reset pulsed low mid-R50 → all `nivel` = 00 asynchronously, `busy` = 0; after release with `req`=0100 held → motor 2 is granted on the second edge.

Source files
------------

// File: rtl/arranque_pkg.sv
// Shared types and level codes for the motor soft-start scheduler.
// Pure definitions: no logic, no latency, no flow control.
package arranque_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R30  = 2'd1,
    R50  = 2'd2
  } estado_sched_t;

  localparam logic [1:0] NIVEL_OFF = 2'b00;
  localparam logic [1:0] NIVEL_30  = 2'b01;
  localparam logic [1:0] NIVEL_50  = 2'b10;
  localparam logic [1:0] NIVEL_100 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending motor at or after ptr.
// Combinational, zero latency; no backpressure (valid low when nothing pending).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);
  localparam int SW    = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] j;

  // Walk from the farthest offset down so the nearest pending motor wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      j = sum[IDX_W-1:0];
      if (pending[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/motor_arranque_scheduler.sv
// Grants one motor at a time a 30%/50%/100% soft-start ramp, round-robin.
// Grant one edge after req is seen in IDLE; requests simply wait while a ramp runs.
module motor_arranque_scheduler
  import arranque_pkg::*;
#(
  parameter int N_MOTORES = 4,
  parameter int CNT_W     = 16,
  parameter int DWELL_30  = 1000,
  parameter int DWELL_50  = 1000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_MOTORES-1:0]         req,
  input  logic [N_MOTORES-1:0]         rapido,
  output logic [2*N_MOTORES-1:0]       nivel,
  output logic                         busy,
  output logic [$clog2(N_MOTORES)-1:0] grant_idx,
  output logic                         done
);

  localparam int IDX_W = $clog2(N_MOTORES);
  localparam logic [CNT_W-1:0] LOAD_30 = CNT_W'(DWELL_30 - 1);
  localparam logic [CNT_W-1:0] LOAD_50 = CNT_W'(DWELL_50 - 1);

  estado_sched_t                 state, state_n;
  logic [CNT_W-1:0]              cnt, cnt_n;
  logic [IDX_W-1:0]              grant_q, grant_n;
  logic [IDX_W-1:0]              rr_ptr, rr_n;
  logic [N_MOTORES-1:0]          running, running_n;
  logic [N_MOTORES-1:0][1:0]     nivel_q, nivel_n;
  logic                          done_q, done_n;

  logic [N_MOTORES-1:0]          ramp_mask;
  logic [N_MOTORES-1:0]          pending;
  logic                          arb_valid;
  logic [IDX_W-1:0]              arb_idx;

  assign ramp_mask = (state != IDLE) ? (N_MOTORES'(1) << grant_q) : '0;
  assign pending   = req & ~running & ~ramp_mask;

  rr_arbiter #(.N(N_MOTORES)) u_rr_arbiter (
    .pending (pending),
    .ptr     (rr_ptr),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    grant_n   = grant_q;
    rr_n      = rr_ptr;
    running_n = running;
    nivel_n   = nivel_q;
    done_n    = 1'b0;

    // Running motors drop out whenever their request goes away.
    for (int i = 0; i < N_MOTORES; i++) begin
      if (running[i] && !req[i]) begin
        running_n[i] = 1'b0;
        nivel_n[i]   = NIVEL_OFF;
      end
    end

    case (state)
      IDLE: begin
        if (arb_valid) begin
          grant_n = arb_idx;
          rr_n    = (arb_idx == IDX_W'(N_MOTORES - 1)) ? '0 : arb_idx + IDX_W'(1);
          if (rapido[arb_idx]) begin
            state_n          = R50;
            cnt_n            = LOAD_50;
            nivel_n[arb_idx] = NIVEL_50;
          end else begin
            state_n          = R30;
            cnt_n            = LOAD_30;
            nivel_n[arb_idx] = NIVEL_30;
          end
        end
      end
      R30: begin
        // Abort takes priority over dwell expiry.
        if (!req[grant_q]) begin
          state_n          = IDLE;
          nivel_n[grant_q] = NIVEL_OFF;
        end else if (cnt == '0) begin
          state_n          = R50;
          cnt_n            = LOAD_50;
          nivel_n[grant_q] = NIVEL_50;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      R50: begin
        if (!req[grant_q]) begin
          state_n          = IDLE;
          nivel_n[grant_q] = NIVEL_OFF;
        end else if (cnt == '0) begin
          state_n            = IDLE;
          running_n[grant_q] = 1'b1;
          nivel_n[grant_q]   = NIVEL_100;
          done_n             = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      grant_q <= '0;
      rr_ptr  <= '0;
      running <= '0;
      nivel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      grant_q <= grant_n;
      rr_ptr  <= rr_n;
      running <= running_n;
      nivel_q <= nivel_n;
      done_q  <= done_n;
    end
  end

  assign nivel     = nivel_q;
  assign busy      = (state != IDLE);
  assign grant_idx = grant_q;
  assign done      = done_q;

endmodule

// File: tb/tb_motor_arranque_scheduler.sv
// Self-checking bench for motor_arranque_scheduler: N=4, DWELL_30=3, DWELL_50=2.
// Grant order and done pulses are scoreboarded; level sequences are checked inline.
module tb_motor_arranque_scheduler;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] rapido;
  logic [2*N-1:0] nivel;
  logic         busy;
  logic [1:0]   grant_idx;
  logic         done;

  int tests;
  int fails;

  int exp_grant[$];
  int exp_done[$];
  logic busy_q;

  motor_arranque_scheduler #(
    .N_MOTORES (N),
    .CNT_W     (16),
    .DWELL_30  (3),
    .DWELL_50  (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .rapido    (rapido),
    .nivel     (nivel),
    .busy      (busy),
    .grant_idx (grant_idx),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every busy rising edge is a grant, every done pulse a completion.
  always @(negedge clk) begin
    int e;
    if (reset_n === 1'b1) begin
      if (busy === 1'b1 && busy_q !== 1'b1) begin
        tests++;
        if (exp_grant.size() == 0) begin
          fails++;
          $display("FAIL grant_order: got grant %0d, required no grant", grant_idx);
        end else begin
          e = exp_grant.pop_front();
          if (int'(grant_idx) != e) begin
            fails++;
            $display("FAIL grant_order: got grant %0d, required %0d", grant_idx, e);
          end
        end
      end
      if (done === 1'b1) begin
        tests++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL done_pulse: got done for %0d, required no done", grant_idx);
        end else begin
          e = exp_done.pop_front();
          if (int'(grant_idx) != e) begin
            fails++;
            $display("FAIL done_pulse: got done for %0d, required %0d", grant_idx, e);
          end
        end
      end
    end
    busy_q = busy;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    rapido  = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if (nivel !== 8'h00) begin fails++; $display("FAIL reset_nivel: got %h, required 00", nivel); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++;
    if (grant_idx !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d, required 0", grant_idx); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_ramp();
    // {nivel[1:0], done, busy} for the seven cycles after the request is seen
    logic [3:0] tbl [7];
    logic [3:0] obs;
    tbl = '{4'b0101, 4'b0101, 4'b0101, 4'b1001, 4'b1001, 4'b1110, 4'b1100};
    @(negedge clk);
    req = 4'b0001;
    exp_grant.push_back(0);
    exp_done.push_back(0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      obs = {nivel[1:0], done, busy};
      tests++;
      if (obs !== tbl[c]) begin
        fails++;
        $display("FAIL single_ramp cycle %0d: got {nivel,done,busy}=%b, required %b", c + 1, obs, tbl[c]);
      end
    end
    tests++;
    if (nivel[7:2] !== 6'b0) begin fails++; $display("FAIL single_others: got %b, required 000000", nivel[7:2]); end
    req = 4'b0000;
    @(negedge clk);
    tests++;
    if (nivel !== 8'h00) begin fails++; $display("FAIL single_stop: got %h, required 00", nivel); end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    for (int m = 0; m < 4; m++) begin
      exp_grant.push_back(m);
      exp_done.push_back(m);
    end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1 || c == 7 || c == 13 || c == 19) begin
        tests++;
        if (busy !== 1'b1 || int'(grant_idx) != (c - 1) / 6) begin
          fails++;
          $display("FAIL rr_spacing cycle %0d: got busy=%b grant=%0d, required busy=1 grant=%0d", c, busy, grant_idx, (c - 1) / 6);
        end
      end
      if (c == 6 || c == 12 || c == 18) begin
        tests++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          fails++;
          $display("FAIL rr_gap cycle %0d: got busy=%b done=%b, required busy=0 done=1", c, busy, done);
        end
      end
    end
    tests++;
    if (nivel !== 8'hFF) begin fails++; $display("FAIL rr_all_full: got %h, required ff", nivel); end
  endtask

  task automatic test_rapido();
    logic [1:0] tbl [4];
    tbl = '{2'b10, 2'b10, 2'b11, 2'b11};
    do_reset();
    @(negedge clk);
    rapido = 4'b0010;
    req    = 4'b0010;
    exp_grant.push_back(1);
    exp_done.push_back(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (nivel[3:2] !== tbl[c]) begin
        fails++;
        $display("FAIL rapido_level cycle %0d: got %b, required %b", c + 1, nivel[3:2], tbl[c]);
      end
      if (c == 0) rapido = 4'b0000;
      if (c == 2) begin
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL rapido_done: got %b, required 1", done); end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge clk);
    req = 4'b1100;
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_done.push_back(3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if (nivel[5:4] !== 2'b01) begin
        fails++;
        $display("FAIL abort_r30 cycle %0d: got %b, required 01", c, nivel[5:4]);
      end
    end
    req = 4'b1000;
    @(negedge clk);
    tests++;
    if ({nivel[5:4], busy, done} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_off: got {nivel,busy,done}=%b, required 0000", {nivel[5:4], busy, done});
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || grant_idx !== 2'd3 || nivel[7:6] !== 2'b01) begin
      fails++;
      $display("FAIL abort_next: got busy=%b grant=%0d lvl=%b, required busy=1 grant=3 lvl=01", busy, grant_idx, nivel[7:6]);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (nivel !== 8'hC0) begin fails++; $display("FAIL abort_final: got %h, required c0", nivel); end
  endtask

  task automatic test_running_drop();
    do_reset();
    @(negedge clk);
    req = 4'b0011;
    for (int m = 0; m < 3; m++) begin
      exp_grant.push_back(m);
      exp_done.push_back(m);
    end
    repeat (12) @(negedge clk);
    tests++;
    if (nivel !== 8'h0F) begin fails++; $display("FAIL drop_setup: got %h, required 0f", nivel); end
    req = 4'b0111;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || grant_idx !== 2'd2 || nivel[5:4] !== 2'b01) begin
      fails++;
      $display("FAIL drop_grant2: got busy=%b grant=%0d lvl=%b, required busy=1 grant=2 lvl=01", busy, grant_idx, nivel[5:4]);
    end
    @(negedge clk);
    req = 4'b0110;
    @(negedge clk);
    tests++;
    if (nivel !== 8'h1C) begin fails++; $display("FAIL drop_motor0: got %h, required 1c", nivel); end
    @(negedge clk);
    tests++;
    if (nivel[5:4] !== 2'b10) begin fails++; $display("FAIL drop_ramp50: got %b, required 10", nivel[5:4]); end
    repeat (2) @(negedge clk);
    tests++;
    if (nivel !== 8'h3C || done !== 1'b1) begin
      fails++;
      $display("FAIL drop_final: got nivel=%h done=%b, required nivel=3c done=1", nivel, done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    exp_grant.push_back(0);
    repeat (4) @(negedge clk);
    tests++;
    if (nivel[1:0] !== 2'b10) begin fails++; $display("FAIL midrst_r50: got %b, required 10", nivel[1:0]); end
    reset_n = 1'b0;
    req     = 4'b0100;
    #1;
    tests++;
    if (nivel !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || grant_idx !== 2'd0) begin
      fails++;
      $display("FAIL midrst_async: got nivel=%h busy=%b done=%b grant=%0d, required 00/0/0/0", nivel, busy, done, grant_idx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_grant.push_back(2);
    exp_done.push_back(2);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || grant_idx !== 2'd2 || nivel !== 8'h10) begin
      fails++;
      $display("FAIL midrst_regrant: got busy=%b grant=%0d nivel=%h, required busy=1 grant=2 nivel=10", busy, grant_idx, nivel);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (nivel !== 8'h30) begin fails++; $display("FAIL midrst_final: got %h, required 30", nivel); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    busy_q  = 1'b0;
    reset_n = 1'b1;
    req     = '0;
    rapido  = '0;
    test_reset();
    test_single_ramp();
    test_round_robin();
    test_rapido();
    test_abort();
    test_running_drop();
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests++;
    if (exp_grant.size() != 0) begin
      fails++;
      $display("FAIL grant_queue_empty: got %0d outstanding grants, required 0", exp_grant.size());
    end
    tests++;
    if (exp_done.size() != 0) begin
      fails++;
      $display("FAIL done_queue_empty: got %0d outstanding done, required 0", exp_done.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
